// File: rtl/ram_bus_master.sv
// Single-beat load/store initiator for the asynchronous 4Kx32 RAM bus.
// Optional RAM clear sequencer enabled by defining MEM_CLEAR_EN.
module ram_bus_master #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CLR_CYCLES  = 2
) (
    input  logic                  CLK,
    input  logic                  Rst_n,
`ifdef MEM_CLEAR_EN
    input  logic                  clr_req,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    inout  wire  [DATA_WIDTH-1:0] Mem_Data,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic                  Mem_R_W,
    output logic                  Mem_CS,
    output logic                  Mem_Rst
);

    // Handshake: a request is transferred on a rising CLK edge where
    // req_valid && req_ready; rsp_valid is a single-cycle completion pulse.

    localparam int CNT_MAX = (WAIT_CYCLES > CLR_CYCLES) ? WAIT_CYCLES : CLR_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LOAD  = CW'(CLR_CYCLES - 1);

`ifdef MEM_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE, S_CLEAR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_q, wr_d;
    logic                  cs_q, cs_d;
    logic                  mrst_q, mrst_d;
    logic                  clr_active;
    logic                  handshake;

`ifdef MEM_CLEAR_EN
    assign clr_active = clr_req;
`else
    assign clr_active = 1'b0;
`endif

    assign req_ready = ready_q & ~clr_active;
    assign handshake = (state_q == S_IDLE) && req_valid && req_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
`ifdef MEM_CLEAR_EN
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLR_LOAD;
                end else
`endif
                if (handshake) begin
                    state_d = S_SETUP;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = WAIT_LOAD;
            end
            S_ACCESS: begin
                if (cnt_q == '0) state_d = we_q ? S_HOLD : S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_HOLD: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
`ifdef MEM_CLEAR_EN
            S_CLEAR: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        cs_d        = (state_d == S_ACCESS);
        wr_d        = we_d && ((state_d == S_SETUP) || (state_d == S_ACCESS) ||
                               (state_d == S_HOLD));
`ifdef MEM_CLEAR_EN
        mrst_d      = (state_d == S_CLEAR);
`else
        mrst_d      = 1'b0;
`endif
        rdata_d     = rdata_q;
        if ((state_q == S_ACCESS) && (cnt_q == '0) && !we_q) rdata_d = Mem_Data;
    end

    always_ff @(posedge CLK) begin
        if (!Rst_n) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b0;
            mrst_q      <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            wr_q        <= wr_d;
            cs_q        <= cs_d;
            mrst_q      <= mrst_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign Mem_Addr  = addr_q;
    assign Mem_R_W   = ~wr_q;
    assign Mem_CS    = cs_q;
    assign Mem_Rst   = mrst_q;
    // The bus is driven only in write cycles, which is exactly when Mem_R_W is low.
    assign Mem_Data  = wr_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with behavioural RAMs; a second instance
// uses WAIT_CYCLES=1. The clear test is built only when MEM_CLEAR_EN is defined.
module tb_ram_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    wire  [31:0] mem_data;
    logic [11:0] mem_addr;
    logic        mem_rw, mem_cs, mem_rst;
`ifdef MEM_CLEAR_EN
    logic        clr_req = 1'b0;
`endif

    logic        w1_valid = 1'b0;
    logic [11:0] w1_addr_in = '0;
    logic        w1_ready, w1_rsp_valid;
    logic [31:0] w1_rdata;
    wire  [31:0] w1_data;
    logic [11:0] w1_addr;
    logic        w1_rw, w1_cs, w1_rst;

    logic [31:0] ram  [0:4095];
    logic [31:0] ram1 [0:4095];
    logic [31:0] zval = {32{1'bz}};

    int n_checks = 0;
    int n_fail = 0;
    int viol = 0;
    bit mon_en = 1'b0;
    logic        prev_cs, prev_rw;
    logic [11:0] prev_addr;

    always #5 clk = ~clk;

    ram_bus_master dut (
        .CLK(clk), .Rst_n(rst_n),
`ifdef MEM_CLEAR_EN
        .clr_req(clr_req),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .Mem_Data(mem_data), .Mem_Addr(mem_addr), .Mem_R_W(mem_rw),
        .Mem_CS(mem_cs), .Mem_Rst(mem_rst)
    );

    ram_bus_master #(.WAIT_CYCLES(1)) dut_w1 (
        .CLK(clk), .Rst_n(rst_n),
`ifdef MEM_CLEAR_EN
        .clr_req(1'b0),
`endif
        .req_valid(w1_valid), .req_ready(w1_ready), .req_we(1'b0),
        .req_addr(w1_addr_in), .req_wdata(32'h0),
        .rsp_valid(w1_rsp_valid), .rsp_rdata(w1_rdata),
        .Mem_Data(w1_data), .Mem_Addr(w1_addr), .Mem_R_W(w1_rw),
        .Mem_CS(w1_cs), .Mem_Rst(w1_rst)
    );

    // Asynchronous RAM models: read while selected, write on clock while selected.
    assign mem_data = (mem_cs && mem_rw) ? ram[mem_addr] : {32{1'bz}};
    assign w1_data  = (w1_cs && w1_rw) ? ram1[w1_addr] : {32{1'bz}};

    always @(posedge clk) begin
        if (mem_rst === 1'b1) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'h0;
        end else if (mem_cs === 1'b1 && mem_rw === 1'b0) begin
            ram[mem_addr] <= mem_data;
        end
    end

    initial begin
        ram[12'h020]  = 32'hCAFEF00D;
        ram1[12'h0AB] = 32'h12345678;
    end

    // Bus monitor: driven data only while writing, released otherwise,
    // and CS never toggles on the same edge as address or direction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rw === 1'b0 && (^mem_data) === 1'bx) viol++;
            if (mem_rw === 1'b1 && mem_cs === 1'b0 && mem_data !== zval) viol++;
            if (mem_cs !== prev_cs && (mem_addr !== prev_addr || mem_rw !== prev_rw)) viol++;
        end
        prev_cs   = mem_cs;
        prev_rw   = mem_rw;
        prev_addr = mem_addr;
    end

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                          output int lat, output int cs_cycles, output logic [31:0] rd);
        int guard;
        lat = -1;
        cs_cycles = 0;
        rd = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (mem_cs === 1'b1) cs_cycles++;
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        n_checks++; if (mem_addr !== 12'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        n_checks++; if (mem_rw !== 1'b1) begin n_fail++; $display("FAIL reset_rw got=%b exp=1", mem_rw); end
        n_checks++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs got=%b exp=0", mem_cs); end
        n_checks++; if (mem_rst !== 1'b0) begin n_fail++; $display("FAIL reset_memrst got=%b exp=0", mem_rst); end
        n_checks++; if (mem_data !== zval) begin n_fail++; $display("FAIL reset_bus got=%h exp=z", mem_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_store_load();
        int lat, csc;
        logic [31:0] rd;
        do_req(1'b1, 12'h005, 32'hDEADBEEF, lat, csc, rd);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL store_latency got=%0d exp=5", lat); end
        n_checks++; if (csc !== 2) begin n_fail++; $display("FAIL store_cs_cycles got=%0d exp=2", csc); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata_held got=%h exp=0", rd); end
        do_req(1'b0, 12'h005, 32'h0, lat, csc, rd);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL load_latency got=%0d exp=4", lat); end
        n_checks++; if (csc !== 2) begin n_fail++; $display("FAIL load_cs_cycles got=%0d exp=2", csc); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
        n_checks++; if (mem_addr !== 12'h005) begin n_fail++; $display("FAIL addr_held got=%h exp=005", mem_addr); end
    endtask

    task automatic test_banks();
        int lat, csc;
        logic [31:0] rd;
        logic [11:0] addrs [4];
        addrs = '{12'h000, 12'h400, 12'h800, 12'hC00};
        for (int i = 0; i < 4; i++) do_req(1'b1, addrs[i], 32'(i + 1), lat, csc, rd);
        for (int i = 3; i >= 0; i--) begin
            do_req(1'b0, addrs[i], 32'h0, lat, csc, rd);
            n_checks++;
            if (rd !== 32'(i + 1)) begin
                n_fail++; $display("FAIL bank_load_%0d got=%h exp=%h", i, rd, 32'(i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h0AA; req_wdata = 32'h5A5A1234;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_store_latency got=%0d exp=5", lat); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got=%b exp=0", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_load_latency got=%0d exp=4", lat); end
        n_checks++; if (rsp_rdata !== 32'h5A5A1234) begin n_fail++; $display("FAIL b2b_load_rdata got=%h exp=5a5a1234", rsp_rdata); end
    endtask

    task automatic test_reset_abort();
        int lat, csc, guard, seen;
        logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_wdata = 32'h11112222;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL abort_in_access got=%b exp=1", mem_cs); end
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL abort_cs got=%b exp=0", mem_cs); end
        n_checks++; if (mem_rw !== 1'b1) begin n_fail++; $display("FAIL abort_rw got=%b exp=1", mem_rw); end
        n_checks++; if (mem_data !== zval) begin n_fail++; $display("FAIL abort_bus got=%h exp=z", mem_data); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b exp=0", req_ready); end
        n_checks++; if (mem_addr !== 12'h0) begin n_fail++; $display("FAIL abort_addr got=%h exp=0", mem_addr); end
        seen = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid === 1'b1) seen++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (rsp_valid === 1'b1) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
        mon_en = 1'b1;
        do_req(1'b0, 12'h020, 32'h0, lat, csc, rd);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_prior_data got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_wait1();
        int lat, csc, guard;
        @(negedge clk);
        w1_valid = 1'b1; w1_addr_in = 12'h0AB;
        guard = 0;
        while (!w1_ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        w1_valid = 1'b0;
        lat = 1; csc = 0;
        while (w1_rsp_valid !== 1'b1 && lat < 20) begin
            if (w1_cs === 1'b1) csc++;
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL w1_latency got=%0d exp=3", lat); end
        n_checks++; if (csc !== 1) begin n_fail++; $display("FAIL w1_cs_cycles got=%0d exp=1", csc); end
        n_checks++; if (w1_rdata !== 32'h12345678) begin n_fail++; $display("FAIL w1_rdata got=%h exp=12345678", w1_rdata); end
        n_checks++; if (w1_rst !== 1'b0) begin n_fail++; $display("FAIL w1_memrst got=%b exp=0", w1_rst); end
    endtask

`ifdef MEM_CLEAR_EN
    task automatic test_clear();
        int lat, csc, rst_cycles, n;
        logic [31:0] rd, before;
        do_req(1'b1, 12'h123, 32'hA5A5A5A5, lat, csc, rd);
        before = rsp_rdata;
        @(negedge clk);
        clr_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h123;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        clr_req = 1'b0; req_valid = 1'b0;
        rst_cycles = 0; n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            if (mem_rst === 1'b1) rst_cycles++;
            @(negedge clk);
            n++;
        end
        n_checks++; if (rst_cycles !== 2) begin n_fail++; $display("FAIL clr_pulse got=%0d exp=2", rst_cycles); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL clr_rsp got=%b exp=1", rsp_valid); end
        n_checks++; if (rsp_rdata !== before) begin n_fail++; $display("FAIL clr_rdata_held got=%h exp=%h", rsp_rdata, before); end
        do_req(1'b0, 12'h123, 32'h0, lat, csc, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL clr_load got=%h exp=0", rd); end
    endtask
`endif

    task automatic test_bus_monitor();
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL bus_monitor got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_banks();
        test_back_to_back();
        test_reset_abort();
        test_wait1();
`ifdef MEM_CLEAR_EN
        test_clear();
`endif
        test_bus_monitor();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
